// File: rtl/serial_word_loader_pkg.sv
// Shared types and helpers for the serial word loader: FSM state encoding,
// counter width helper and the even-parity check.
package serial_word_loader_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_LOAD   = 2'd3
  } state_t;

  // Counter width for a WIDTH-bit frame; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Even parity holds when the data XOR combined with the parity bit is zero.
  function automatic logic even_parity_ok(input logic run_xor, input logic par_bit);
    return ~(run_xor ^ par_bit);
  endfunction

endpackage

// File: rtl/serial_word_loader_if.sv
// Handshake and output bundle between a serial bit source and the word loader.
interface serial_word_loader_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic             abort;
  logic             sin_valid;
  logic             sin_bit;
  logic             sin_ready;
  logic             busy;
  logic             load;
  logic [WIDTH-1:0] data_out;
  logic             parity_err;

  modport master (
    output start, abort, sin_valid, sin_bit,
    input  sin_ready, busy, load, data_out, parity_err
  );

  modport slave (
    input  start, abort, sin_valid, sin_bit,
    output sin_ready, busy, load, data_out, parity_err
  );

endinterface

// File: rtl/bit_shift_reg.sv
// WIDTH-bit shift register with synchronous clear and a running XOR of the
// bits shifted in; exposes next-state values so the caller can capture the
// word on the same edge the final bit arrives.
module bit_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q_next,
  output logic             run_xor_next
);

  logic [WIDTH-1:0] q_r;
  logic             run_xor_r;
  logic [WIDTH-1:0] shifted_s;

  // Direction-dependent shift: first bit ends at the MSB or at the LSB.
  always_comb begin
    if (MSB_FIRST) begin
      shifted_s = {q_r[WIDTH-2:0], bit_in};
    end else begin
      shifted_s = {bit_in, q_r[WIDTH-1:1]};
    end
  end

  // Next-state selection; clear wins over shifting.
  always_comb begin
    if (clr) begin
      q_next       = {WIDTH{1'b0}};
      run_xor_next = 1'b0;
    end else if (shift_en) begin
      q_next       = shifted_s;
      run_xor_next = run_xor_r ^ bit_in;
    end else begin
      q_next       = q_r;
      run_xor_next = run_xor_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r       <= {WIDTH{1'b0}};
      run_xor_r <= 1'b0;
    end else begin
      q_r       <= q_next;
      run_xor_r <= run_xor_next;
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader feeding a WIDTH-bit load register.
// Optional even-parity bit per frame when SERIAL_LOADER_PARITY_EN is defined.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_loader_if.slave  bus
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ready_r;
  logic             busy_r;
  logic             load_r;
  logic [WIDTH-1:0] data_r;
  logic             accept_s;
  logic             clr_s;
  logic             shift_en_s;
  logic [WIDTH-1:0] word_next_s;
  logic             xor_next_s;

  // Abort masks ready combinationally so no bit is taken in an aborting cycle.
  assign bus.sin_ready = ready_r & ~bus.abort;
  assign accept_s      = bus.sin_valid & bus.sin_ready;
  assign clr_s         = (state_r == ST_IDLE) & bus.start & ~bus.abort;
  assign shift_en_s    = (state_r == ST_SHIFT) & accept_s;

  assign bus.busy      = busy_r;
  assign bus.load      = load_r;
  assign bus.data_out  = data_r;

  bit_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr_s),
    .shift_en     (shift_en_s),
    .bit_in       (bus.sin_bit),
    .q_next       (word_next_s),
    .run_xor_next (xor_next_s)
  );

`ifdef SERIAL_LOADER_PARITY_EN
  logic perr_r;
  assign bus.parity_err = perr_r;
`else
  logic parity_unused_s;
  assign parity_unused_s = xor_next_s;
  assign bus.parity_err  = 1'b0;
`endif

  // Frame FSM with counter and registered outputs; abort overrides every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      load_r  <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
`ifdef SERIAL_LOADER_PARITY_EN
      perr_r  <= 1'b0;
`endif
    end else begin
      load_r <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
      perr_r <= 1'b0;
`endif
      if (bus.abort) begin
        state_r <= ST_IDLE;
        ready_r <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.start) begin
              state_r <= ST_SHIFT;
              cnt_r   <= {CNT_W{1'b0}};
              ready_r <= 1'b1;
              busy_r  <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (accept_s) begin
              if (cnt_r == CNT_LAST) begin
`ifdef SERIAL_LOADER_PARITY_EN
                state_r <= ST_PARITY;
`else
                state_r <= ST_LOAD;
                ready_r <= 1'b0;
                load_r  <= 1'b1;
                data_r  <= word_next_s;
`endif
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
`ifdef SERIAL_LOADER_PARITY_EN
          ST_PARITY: begin
            if (accept_s) begin
              ready_r <= 1'b0;
              if (even_parity_ok(xor_next_s, bus.sin_bit)) begin
                state_r <= ST_LOAD;
                load_r  <= 1'b1;
                data_r  <= word_next_s;
              end else begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                perr_r  <= 1'b1;
              end
            end
          end
`endif
          ST_LOAD: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: an MSB-first and an LSB-first instance driven
// in lockstep, checked against a bit-sequence reference model.
module tb_serial_word_loader;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sin_valid = 1'b0;
  logic sin_bit = 1'b0;

  int tests_run = 0;
  int fails = 0;

  logic [W-1:0] exp_m = '0;
  logic [W-1:0] exp_l = '0;

  always #5 clk = ~clk;

  serial_word_loader_if #(.WIDTH(W)) ifm ();
  serial_word_loader_if #(.WIDTH(W)) ifl ();

  assign ifm.start = start;     assign ifl.start = start;
  assign ifm.abort = abort;     assign ifl.abort = abort;
  assign ifm.sin_valid = sin_valid; assign ifl.sin_valid = sin_valid;
  assign ifm.sin_bit = sin_bit; assign ifl.sin_bit = sin_bit;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bus(ifm.slave));
  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bus(ifl.slave));

  // seq[i] is the i-th bit sent; MSB-first word places the first bit highest.
  function automatic logic [W-1:0] model_msb(input logic [W-1:0] seq);
    int acc = 0;
    for (int i = 0; i < W; i++) acc = acc * 2 + int'(seq[i]);
    return acc[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; sin_valid = 1'b0; sin_bit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) rst = 1'b1;
      tick();
      tests_run++;
      if ({ifm.load, ifm.busy, ifm.sin_ready, ifm.parity_err, ifm.data_out,
           ifl.load, ifl.busy, ifl.sin_ready, ifl.parity_err, ifl.data_out} !== '0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: m(load,busy,rdy,perr,data)=%b%b%b%b %h l=%b%b%b%b %h want all 0",
                 c, ifm.load, ifm.busy, ifm.sin_ready, ifm.parity_err, ifm.data_out,
                 ifl.load, ifl.busy, ifl.sin_ready, ifl.parity_err, ifl.data_out);
      end
    end
  endtask

  // One frame from IDLE; returns one cycle after LOAD (or after the parity error).
  task automatic run_frame(input logic [W-1:0] seq, input int stall_at,
                           input int stall_len, input logic par_bit,
                           input logic start_in_load);
    logic [W-1:0] em, el;
    logic par_ok;
    em = model_msb(seq);
    el = seq;
    par_ok = ((^seq) ^ par_bit) == 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if ({ifm.busy, ifm.sin_ready, ifl.busy, ifl.sin_ready} !== 4'b1111) begin
      fails++;
      $display("FAIL frame_start: busy/ready m=%b%b l=%b%b want 1111",
               ifm.busy, ifm.sin_ready, ifl.busy, ifl.sin_ready);
    end
    for (int i = 0; i < W; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          sin_valid = 1'b0;
          tick();
          tests_run++;
          if ({ifm.sin_ready, ifl.sin_ready, ifm.load, ifl.load} !== 4'b1100) begin
            fails++;
            $display("FAIL stall: ready/load m=%b/%b l=%b/%b want ready 1 load 0",
                     ifm.sin_ready, ifm.load, ifl.sin_ready, ifl.load);
          end
        end
      end
      sin_valid = 1'b1;
      sin_bit = seq[i];
      tick();
      if (i < W - 1) begin
        tests_run++;
        if ({ifm.load, ifl.load} !== 2'b00) begin
          fails++;
          $display("FAIL early_load bit %0d: load m=%b l=%b want 0", i, ifm.load, ifl.load);
        end
      end
    end
`ifdef SERIAL_LOADER_PARITY_EN
    tests_run++;
    if ({ifm.load, ifl.load, ifm.sin_ready} !== 3'b001) begin
      fails++;
      $display("FAIL parity_wait: load m=%b l=%b ready=%b want 0 0 1", ifm.load, ifl.load, ifm.sin_ready);
    end
    sin_bit = par_bit;
    tick();
`endif
    sin_valid = 1'b0;
    start = start_in_load;
`ifdef SERIAL_LOADER_PARITY_EN
    if (!par_ok) begin
      tests_run++;
      if ({ifm.parity_err, ifl.parity_err, ifm.load, ifl.load, ifm.busy} !== 5'b11000 ||
          ifm.data_out !== exp_m || ifl.data_out !== exp_l) begin
        fails++;
        $display("FAIL parity_err: perr m=%b l=%b load=%b%b busy=%b data m=%h l=%h want perr 1 load 0 data %h %h",
                 ifm.parity_err, ifl.parity_err, ifm.load, ifl.load, ifm.busy,
                 ifm.data_out, ifl.data_out, exp_m, exp_l);
      end
    end else
`endif
    begin
      exp_m = em;
      exp_l = el;
      tests_run++;
      if ({ifm.load, ifl.load, ifm.busy, ifm.parity_err, ifl.parity_err} !== 5'b11100 ||
          ifm.data_out !== exp_m || ifl.data_out !== exp_l) begin
        fails++;
        $display("FAIL load_cycle: load m=%b l=%b busy=%b perr=%b%b data m=%h l=%h want load 1 data %h %h",
                 ifm.load, ifl.load, ifm.busy, ifm.parity_err, ifl.parity_err,
                 ifm.data_out, ifl.data_out, exp_m, exp_l);
      end
    end
    if (par_ok) ;
    tick();
    start = 1'b0;
    tests_run++;
    if ({ifm.load, ifl.load, ifm.busy, ifl.busy, ifm.parity_err} !== 5'b00000 ||
        ifm.data_out !== exp_m || ifl.data_out !== exp_l) begin
      fails++;
      $display("FAIL after_frame: load=%b%b busy=%b%b perr=%b data m=%h l=%h want 0 and data %h %h",
               ifm.load, ifl.load, ifm.busy, ifl.busy, ifm.parity_err,
               ifm.data_out, ifl.data_out, exp_m, exp_l);
    end
  endtask

  task automatic test_msb_pattern();
    run_frame(8'hAA, -1, 0, 1'b0, 1'b0);  // bits 0,1,0,1,... in send order
    tests_run++;
    if (ifm.data_out !== 8'h55) begin
      fails++;
      $display("FAIL msb_pattern: data_out=%h want 55", ifm.data_out);
    end
  endtask

  task automatic test_stall();
    run_frame(8'h55, 4, 3, 1'b0, 1'b0);
    tests_run++;
    if (ifm.data_out !== 8'hAA || ifl.data_out !== 8'h55) begin
      fails++;
      $display("FAIL stall_words: m=%h l=%h want AA 55", ifm.data_out, ifl.data_out);
    end
  endtask

  task automatic test_abort();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tests_run++;
    if ({ifm.busy, ifl.busy} !== 2'b00) begin
      fails++;
      $display("FAIL start_abort: busy m=%b l=%b want 0", ifm.busy, ifl.busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sin_valid = 1'b1;
      sin_bit = 1'b1;
      tick();
    end
    abort = 1'b1;
    #1;
    tests_run++;
    if ({ifm.sin_ready, ifl.sin_ready} !== 2'b00) begin
      fails++;
      $display("FAIL abort_ready: ready m=%b l=%b want 0", ifm.sin_ready, ifl.sin_ready);
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    sin_valid = 1'b0;
    tests_run++;
    if ({ifm.busy, ifl.busy, ifm.load, ifl.load} !== 4'b0000 ||
        ifm.data_out !== exp_m || ifl.data_out !== exp_l) begin
      fails++;
      $display("FAIL abort_idle: busy=%b%b load=%b%b data m=%h l=%h want 0 and %h %h",
               ifm.busy, ifl.busy, ifm.load, ifl.load, ifm.data_out, ifl.data_out, exp_m, exp_l);
    end
    run_frame(8'hFF, -1, 0, 1'b0, 1'b0);
    tests_run++;
    if (ifm.data_out !== 8'hFF) begin
      fails++;
      $display("FAIL abort_followup: data_out=%h want FF", ifm.data_out);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin_valid = 1'b1;
      sin_bit = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    exp_m = '0;
    exp_l = '0;
    tests_run++;
    if ({ifm.busy, ifl.busy, ifm.sin_ready} !== 3'b000 || ifm.data_out !== 8'h00 ||
        ifl.data_out !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: busy=%b%b ready=%b data m=%h l=%h want 0",
               ifm.busy, ifl.busy, ifm.sin_ready, ifm.data_out, ifl.data_out);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_frame(8'hAA, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_in_load();
    run_frame(8'h3C, -1, 0, 1'b0, 1'b1);  // start held during LOAD must not begin a frame
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] seq;
      logic pb;
      int sat, slen;
      seq  = W'($urandom);
      sat  = int'($urandom_range(0, W));
      slen = int'($urandom_range(0, 3));
      pb   = (^seq) ^ (($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      run_frame(seq, sat, slen, pb, 1'b0);
    end
  endtask

`ifdef SERIAL_LOADER_PARITY_EN
  task automatic test_parity();
    run_frame(8'h55, -1, 0, 1'b0, 1'b0);
    tests_run++;
    if (ifm.data_out !== 8'hAA) begin
      fails++;
      $display("FAIL parity_good: data_out=%h want AA", ifm.data_out);
    end
    run_frame(8'hAA, -1, 0, 1'b1, 1'b0);
    tests_run++;
    if (ifm.data_out !== 8'hAA) begin
      fails++;
      $display("FAIL parity_bad_hold: data_out=%h want AA", ifm.data_out);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_msb_pattern();
    test_stall();
    test_abort();
    test_async_reset();
    test_start_in_load();
`ifdef SERIAL_LOADER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
